boundary_ctrl: RTL and testbench

Alignment controller for the byte-boundary aligner in the transceiver receive path. Searches the incoming comma-flag stream for a configurable comma pattern at every byte offset. Qualifies a candidate offset with a lock/loss state machine with hysteresis, then drives the aligner's byte-offset select. Holds that select stable while locked and re-hunts only after a persistent loss of alignment or a software request.

---
 rtl/boundary_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_boundary_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boundary_ctrl.sv
// Byte-boundary alignment controller: comma search at every byte offset plus a
// HUNT/CHECK/LOCKED qualifier driving the aligner's offset select.
// Optional BOUNDARY_CTRL_STATS_EN adds loss_cnt_o, a saturating LOCKED->HUNT counter.
module boundary_ctrl #(
  parameter int BYTES    = 4,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int TIMEOUT  = 1024,
  localparam int IDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [BYTES-1:0] pattern_i,
  input  logic [BYTES-1:0] comma_i,
  input  logic             force_hunt_i,
  output logic [IDX_W-1:0] index_o,
  output logic             locked_o,
  output logic             hunting_o
`ifdef BOUNDARY_CTRL_STATS_EN
  , output logic [15:0]    loss_cnt_o
`endif
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(LOSS_CNT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] LOCK_V = GW'(LOCK_CNT);
  localparam logic [BW-1:0] LOSS_V = BW'(LOSS_CNT);
  localparam logic [TW-1:0] TMAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] TOUT1  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   index_q, index_d;
  logic [IDX_W-1:0]   cand_q, cand_d;
  logic [GW-1:0]      good_q, good_d;
  logic [BW-1:0]      bad_q, bad_d, bad_inc;
  logic [TW-1:0]      timer_q, timer_d, timer_inc;
  logic [BYTES-1:0]   comma_r1_q;
  logic               hit_q, hit_d;
  logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;
  logic [2*BYTES-1:0] window;

  assign window = {comma_i, comma_r1_q};

  // Scan from the top offset down so the lowest matching offset is the one kept.
  always_comb begin
    hit_d     = 1'b0;
    hit_idx_d = '0;
    if (pattern_i != '0) begin
      for (int k = BYTES - 1; k >= 0; k--) begin
        if (window[k +: BYTES] == pattern_i) begin
          hit_d     = 1'b1;
          hit_idx_d = IDX_W'(k);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    cand_d    = cand_q;
    good_d    = good_q;
    bad_d     = bad_q;
    timer_d   = timer_q;
    bad_inc   = bad_q + BW'(1);
    timer_inc = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
    if (force_hunt_i) begin
      state_d = HUNT;
      good_d  = '0;
      bad_d   = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (hit_q) begin
            cand_d  = hit_idx_q;
            good_d  = GW'(1);
            timer_d = '0;
            if (LOCK_CNT == 1) begin
              state_d = LOCKED;
              index_d = hit_idx_q;
              bad_d   = '0;
            end else begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (hit_q && (hit_idx_q == cand_q)) begin
            good_d  = good_q + GW'(1);
            timer_d = '0;
            if (good_q + GW'(1) == LOCK_V) begin
              state_d = LOCKED;
              index_d = cand_q;
              bad_d   = '0;
            end
          end else if (hit_q) begin
            cand_d  = hit_idx_q;
            good_d  = GW'(1);
            timer_d = '0;
          end else if (timer_q >= TOUT1) begin
            state_d = HUNT;
            good_d  = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_inc;
          end
        end
        LOCKED: begin
          if (hit_q && (hit_idx_q == index_q)) begin
            bad_d   = '0;
            timer_d = '0;
          end else begin
            if (hit_q)                 timer_d = timer_inc;
            else if (timer_q >= TOUT1) timer_d = '0;
            else                       timer_d = timer_inc;
            // A wrong-offset hit and a timer expiry are each one error.
            if (hit_q || (timer_q >= TOUT1)) begin
              if (bad_inc == LOSS_V) begin
                state_d = HUNT;
                bad_d   = '0;
                good_d  = '0;
                timer_d = '0;
              end else begin
                bad_d = bad_inc;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= HUNT;
      index_q    <= '0;
      cand_q     <= '0;
      good_q     <= '0;
      bad_q      <= '0;
      timer_q    <= '0;
      comma_r1_q <= '0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      cand_q     <= cand_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      timer_q    <= timer_d;
      comma_r1_q <= comma_i;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
    end
  end

  assign index_o   = index_q;
  assign locked_o  = (state_q == LOCKED);
  assign hunting_o = (state_q == HUNT);

`ifdef BOUNDARY_CTRL_STATS_EN
  logic [15:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if ((state_q == LOCKED) && (state_d == HUNT) && (loss_q != 16'hFFFF))
      loss_d = loss_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) loss_q <= '0;
    else         loss_q <= loss_d;
  end

  assign loss_cnt_o = loss_q;
`endif

endmodule

// File: tb/tb_boundary_ctrl.sv
// Bench for boundary_ctrl: a behavioural model pushes expected outputs per edge,
// popped and compared after the edge, plus directed checks of lock/loss scenarios.
module tb_boundary_ctrl;
  localparam int BYTES    = 4;
  localparam int LOCK_CNT = 4;
  localparam int LOSS_CNT = 3;
  localparam int TIMEOUT  = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] pattern;
  logic [3:0] comma;
  logic       fh;
  logic [1:0] index;
  logic       locked;
  logic       hunting;
`ifdef BOUNDARY_CTRL_STATS_EN
  logic [15:0] loss_cnt;
`endif

  boundary_ctrl #(
    .BYTES(BYTES), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .pattern_i(pattern),
    .comma_i(comma),
    .force_hunt_i(fh),
    .index_o(index),
    .locked_o(locked),
    .hunting_o(hunting)
`ifdef BOUNDARY_CTRL_STATS_EN
    , .loss_cnt_o(loss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0]  idx;
    logic        lk;
    logic        hu;
    logic [15:0] lc;
  } exp_t;
  exp_t sb[$];

  // Model state: 0=HUNT 1=CHECK 2=LOCKED
  int         m_state, m_idx, m_cand, m_good, m_bad, m_tmr, m_hidx, m_loss;
  bit         m_hit;
  logic [3:0] m_r1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_cand = 0; m_good = 0; m_bad = 0;
    m_tmr = 0; m_hit = 0; m_hidx = 0; m_loss = 0; m_r1 = '0;
  endtask

  task automatic model_edge();
    logic [7:0] w;
    bit         nh, err;
    int         ni;
    w  = {comma, m_r1};
    nh = 0;
    ni = 0;
    for (int k = 0; k < BYTES; k++)
      if (!nh && pattern != 4'b0 && w[k +: 4] == pattern) begin nh = 1; ni = k; end
    if (fh) begin
      if (m_state == 2 && m_loss < 65535) m_loss++;
      m_state = 0; m_good = 0; m_bad = 0; m_tmr = 0;
    end else if (m_state == 0) begin
      if (m_hit) begin
        m_cand = m_hidx; m_good = 1; m_tmr = 0;
        if (LOCK_CNT == 1) begin m_state = 2; m_idx = m_hidx; m_bad = 0; end
        else m_state = 1;
      end
    end else if (m_state == 1) begin
      if (m_hit && m_hidx == m_cand) begin
        m_good++; m_tmr = 0;
        if (m_good == LOCK_CNT) begin m_state = 2; m_idx = m_cand; m_bad = 0; end
      end else if (m_hit) begin
        m_cand = m_hidx; m_good = 1; m_tmr = 0;
      end else if (m_tmr >= TIMEOUT - 1) begin
        m_state = 0; m_good = 0; m_tmr = 0;
      end else m_tmr++;
    end else begin
      if (m_hit && m_hidx == m_idx) begin
        m_bad = 0; m_tmr = 0;
      end else begin
        err = m_hit || (m_tmr >= TIMEOUT - 1);
        if (m_hit) m_tmr = (m_tmr < TIMEOUT) ? m_tmr + 1 : m_tmr;
        else if (m_tmr >= TIMEOUT - 1) m_tmr = 0;
        else m_tmr++;
        if (err) begin
          m_bad++;
          if (m_bad == LOSS_CNT) begin
            m_state = 0; m_bad = 0; m_tmr = 0; m_good = 0;
            if (m_loss < 65535) m_loss++;
          end
        end
      end
    end
    m_r1  = comma;
    m_hit = nh;
    m_hidx = ni;
  endtask

  task automatic push_exp();
    exp_t e;
    e.idx = m_idx[1:0];
    e.lk  = (m_state == 2);
    e.hu  = (m_state == 0);
    e.lc  = m_loss[15:0];
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("index", {30'd0, index}, {30'd0, e.idx});
      chk("locked", {31'd0, locked}, {31'd0, e.lk});
      chk("hunting", {31'd0, hunting}, {31'd0, e.hu});
`ifdef BOUNDARY_CTRL_STATS_EN
      chk("loss_cnt", {16'd0, loss_cnt}, {16'd0, e.lc});
`endif
    end
  endtask

  task automatic step(input logic [3:0] c, input logic f);
    comma = c;
    fh    = f;
    @(posedge clk);
    model_edge();
    push_exp();
    #1;
    compare_out();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(4'b0, 1'b0);
  endtask

  // Comma at byte k of one word, then a clean word: the window matches at offset k.
  task automatic hit_at(input int k);
    step(4'(1 << k), 1'b0);
    step(4'b0, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    comma = '0;
    fh    = 1'b0;
    rstn  = 1'b0;
    model_reset();
    push_exp();
    #1;
    compare_out();
    chk("rst_index", {30'd0, index}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_hunting", {31'd0, hunting}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] pats [4];
    pats[0] = 4'b0001; pats[1] = 4'b0011; pats[2] = 4'b0101; pats[3] = 4'b0000;
    pattern = 4'b0001;
    comma   = '0;
    fh      = 1'b0;
    model_reset();
    do_reset();

    // Lock at offset 2, one match every 8 cycles
    for (int i = 0; i < 4; i++) begin
      hit_at(2);
      if (i < 3) gap(6);
    end
    chk("lock_not_yet", {31'd0, locked}, 32'd0);
    chk("lock_idx_held", {30'd0, index}, 32'd0);
    step(4'b0, 1'b0);
    chk("lock_locked", {31'd0, locked}, 32'd1);
    chk("lock_index", {30'd0, index}, 32'd2);

    // Misalignment loss: three hits at offset 1
    for (int i = 0; i < 3; i++) begin hit_at(1); gap(2); end
    chk("mis_locked", {31'd0, locked}, 32'd0);
    chk("mis_hunting", {31'd0, hunting}, 32'd1);
    chk("mis_index", {30'd0, index}, 32'd2);
`ifdef BOUNDARY_CTRL_STATS_EN
    chk("mis_losscnt", {16'd0, loss_cnt}, 32'd1);
`endif

    // Candidate change inside CHECK
    hit_at(2); gap(2); hit_at(2); gap(2);
    hit_at(3); gap(2);
    chk("cc_in_check", {31'd0, hunting}, 32'd0);
    chk("cc_not_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 2; i++) begin hit_at(3); gap(2); end
    chk("cc_still_check", {31'd0, locked}, 32'd0);
    hit_at(3);
    step(4'b0, 1'b0);
    chk("cc_locked", {31'd0, locked}, 32'd1);
    chk("cc_index", {30'd0, index}, 32'd3);

    // Timeout loss with no commas at all
    n = 0;
    while (locked && n < 200) begin step(4'b0, 1'b0); n++; end
    chk("tmo_cycles_in_window", {31'd0, (n >= 47 && n <= 49)}, 32'd1);
    chk("tmo_index", {30'd0, index}, 32'd3);
`ifdef BOUNDARY_CTRL_STATS_EN
    chk("tmo_losscnt", {16'd0, loss_cnt}, 32'd2);
`endif

    // Force hunt coincident with a valid hit
    for (int i = 0; i < 4; i++) begin hit_at(0); gap(2); end
    chk("sim_pre_locked", {31'd0, locked}, 32'd1);
    hit_at(0);
    step(4'b0, 1'b1);
    chk("sim_hunting", {31'd0, hunting}, 32'd1);
    chk("sim_locked", {31'd0, locked}, 32'd0);
`ifdef BOUNDARY_CTRL_STATS_EN
    chk("sim_losscnt", {16'd0, loss_cnt}, 32'd3);
`endif
    for (int i = 0; i < 3; i++) begin hit_at(0); gap(2); end
    chk("relock_wait", {31'd0, locked}, 32'd0);
    hit_at(0);
    step(4'b0, 1'b0);
    chk("relock_done", {31'd0, locked}, 32'd1);

    // All-zero pattern never matches
    pattern = 4'b0000;
    for (int i = 0; i < 30; i++) step(4'($urandom), 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 100 == 0) pattern = pats[$urandom_range(0, 3)];
      step(($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0,
           ($urandom_range(0, 79) == 0));
    end

    // Reset while locked
    pattern = 4'b0001;
    step(4'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin hit_at(1); gap(1); end
    chk("pre_rst_locked", {31'd0, locked}, 32'd1);
    chk("pre_rst_index", {30'd0, index}, 32'd1);
    do_reset();
    hit_at(2);
    gap(2);
    chk("post_rst_check", {31'd0, hunting}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, n_bad);
    $finish;
  end

endmodule
